// File: rtl/program_loader.sv
// program_loader: 16 x 8 instruction store with a byte-serial load port and
// the boot sequencer that keeps the downstream CPU in reset until a program
// load (or an explicit run request) has completed.
module program_loader #(
    parameter int RELEASE_DELAY = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_start,
    input  logic       run_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic [3:0] addr,
    output logic [3:0] opecode,
    output logic [3:0] imm,
    output logic       cpu_n_rst,
    output logic [4:0] load_count
);

    typedef enum logic [1:0] {HOLD, LOAD, WAIT, RUN} state_t;

    // Last WAIT count before release; WAIT always starts from cnt = 0.
    localparam logic [3:0] CNT_LAST = 4'(RELEASE_DELAY - 1);

    state_t           state, state_nxt;
    logic [15:0][7:0] mem;
    logic [3:0]       wptr;
    logic [3:0]       cnt;
    logic             accept;

    // A byte presented together with load_start is dropped by the restart.
    assign accept = (state == LOAD) && load_valid && !load_start;

    // Combinational program fetch; a same-cycle write is not visible yet.
    assign opecode = mem[addr][7:4];
    assign imm     = mem[addr][3:0];

    // State register; cpu_n_rst is registered off the next state so it
    // rises on the edge entering RUN and falls on the edge leaving it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= HOLD;
            cpu_n_rst <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_n_rst <= (state_nxt == RUN);
        end
    end

    // Next-state and load handshake decode; load_start dominates everywhere.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        case (state)
            HOLD: begin
                if (load_start)     state_nxt = LOAD;
                else if (run_start) state_nxt = WAIT;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (accept && wptr == 4'd15) state_nxt = WAIT;
            end
            WAIT: begin
                if (load_start)            state_nxt = LOAD;
                else if (cnt == CNT_LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (load_start) state_nxt = LOAD;
            end
            default: state_nxt = HOLD;
        endcase
    end

    // Write pointer, byte count and release counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr       <= 4'd0;
            load_count <= 5'd0;
            cnt        <= 4'd0;
        end else begin
            if (load_start) begin
                wptr       <= 4'd0;
                load_count <= 5'd0;
            end else if (accept) begin
                wptr       <= wptr + 4'd1;
                load_count <= load_count + 5'd1;
            end
            cnt <= (state == WAIT) ? cnt + 4'd1 : 4'd0;
        end
    end

    // Program memory; cleared by reset, one byte written per accept.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (accept) begin
            mem[wptr] <= load_data;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven stimulus for program_loader with a
// scoreboard of per-cycle expected outputs and a reference program memory.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       load_start = 1'b0;
    logic       run_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready;
    logic [3:0] addr = 4'd0;
    logic [3:0] opecode;
    logic [3:0] imm;
    logic       cpu_n_rst;
    logic [4:0] load_count;

    int checks = 0;
    int failures = 0;

    program_loader #(.RELEASE_DELAY(2)) dut (
        .clk(clk), .n_rst(n_rst), .load_start(load_start), .run_start(run_start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .addr(addr), .opecode(opecode), .imm(imm), .cpu_n_rst(cpu_n_rst),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ls;
        logic       rs;
        logic       v;
        logic [7:0] d;
        logic [4:0] ecnt;
        logic       erdy;
        logic       ecpu;
    } vec_t;

    typedef struct packed {
        logic [4:0] c;
        logic       r;
        logic       p;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_mem[16];
    logic       m_load = 1'b0;
    logic [3:0] m_wptr = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, predict memory, push expectations, pop after the edge.
    task automatic apply(input vec_t t);
        exp_t e;
        load_start = t.ls; run_start = t.rs; load_valid = t.v; load_data = t.d;
        if (t.ls) begin
            m_load = 1'b1; m_wptr = 4'd0;
        end else if (m_load && t.v) begin
            exp_mem[m_wptr] = t.d;
            if (m_wptr == 4'd15) m_load = 1'b0;
            m_wptr = m_wptr + 4'd1;
        end
        sb.push_back({t.ecnt, t.erdy, t.ecpu});
        @(posedge clk); #1;
        load_start = 1'b0; run_start = 1'b0; load_valid = 1'b0;
        e = sb.pop_front();
        check("load_count", int'(load_count), int'(e.c));
        check("load_ready", int'(load_ready), int'(e.r));
        check("cpu_n_rst", int'(cpu_n_rst), int'(e.p));
    endtask

    task automatic check_mem(input string name);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            check(name, int'({opecode, imm}), int'(exp_mem[a]));
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = 8'h00;
        m_load = 1'b0; m_wptr = 4'd0;
        #1;
        check("rst_cpu_n_rst", int'(cpu_n_rst), 0);
        check("rst_load_ready", int'(load_ready), 0);
        check("rst_load_count", int'(load_count), 0);
        check_mem("rst_mem");
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    function automatic vec_t mk(logic ls, logic rs, logic v, logic [7:0] d,
                                logic [4:0] c, logic r, logic p);
        vec_t t;
        t.ls = ls; t.rs = rs; t.v = v; t.d = d; t.ecnt = c; t.erdy = r; t.ecpu = p;
        return t;
    endfunction

    initial begin
        vec_t stall_tbl[4];
        vec_t restart_tbl[8];
        logic [7:0] b;

        stall_tbl[0] = mk(0, 0, 1, 8'hA5, 5'd1, 1, 0);
        stall_tbl[1] = mk(0, 0, 0, 8'hFF, 5'd1, 1, 0);
        stall_tbl[2] = mk(0, 0, 0, 8'h00, 5'd1, 1, 0);
        stall_tbl[3] = mk(0, 0, 1, 8'h5A, 5'd2, 1, 0);

        restart_tbl[0] = mk(1, 0, 0, 8'h00, 5'd0, 1, 0);
        restart_tbl[1] = mk(0, 0, 1, 8'h11, 5'd1, 1, 0);
        restart_tbl[2] = mk(0, 0, 1, 8'h22, 5'd2, 1, 0);
        restart_tbl[3] = mk(0, 0, 1, 8'h33, 5'd3, 1, 0);
        restart_tbl[4] = mk(0, 0, 1, 8'h44, 5'd4, 1, 0);
        restart_tbl[5] = mk(0, 0, 1, 8'h55, 5'd5, 1, 0);
        restart_tbl[6] = mk(1, 0, 1, 8'hEE, 5'd0, 1, 0);
        restart_tbl[7] = mk(0, 0, 1, 8'h77, 5'd1, 1, 0);

        // Mid-cycle asynchronous reset from power-up.
        #3;
        do_reset();

        // Full load: 30, 01, 12, ..., E? , F3.
        apply(mk(1, 0, 0, 8'h00, 5'd0, 1, 0));
        load_valid = 1'b1; load_data = 8'h30; addr = 4'd0; #1;
        check("read_before_write", int'({opecode, imm}), 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 0)       b = 8'h30;
            else if (i == 15) b = 8'hF3;
            else              b = {4'(i - 1), 4'(i)};
            apply(mk(0, 0, 1, b, 5'(i + 1), (i < 15), 0));
        end
        apply(mk(0, 0, 0, 8'h00, 5'd16, 0, 0));
        apply(mk(0, 0, 0, 8'h00, 5'd16, 0, 1));
        check_mem("full_load_mem");
        addr = 4'd0; #1;
        check("addr0_opecode", int'(opecode), 3);
        check("addr0_imm", int'(imm), 0);
        addr = 4'd15; #1;
        check("addr15_opecode", int'(opecode), 15);
        check("addr15_imm", int'(imm), 3);

        // Reload from RUN drops cpu_n_rst on the sampling edge.
        apply(mk(1, 0, 0, 8'h00, 5'd0, 1, 0));

        // Stalled transfer: only two bytes land.
        foreach (stall_tbl[i]) apply(stall_tbl[i]);
        apply(mk(0, 0, 0, 8'h00, 5'd2, 1, 0));
        apply(mk(0, 0, 0, 8'h00, 5'd2, 1, 0));
        check_mem("stall_mem");
        addr = 4'd2; #1;
        check("stall_entry2_old", int'({opecode, imm}), 'h12);

        // Restart mid-load discards the coincident byte.
        foreach (restart_tbl[i]) apply(restart_tbl[i]);
        check_mem("restart_mem");
        addr = 4'd0; #1;
        check("restart_entry0", int'({opecode, imm}), 'h77);
        addr = 4'd5; #1;
        check("restart_entry5_old", int'({opecode, imm}), 'h45);

        // Finish this load (15 more bytes) to reach WAIT.
        for (int k = 2; k <= 16; k++)
            apply(mk(0, 0, 1, 8'(8'h80 + k), 5'(k), (k < 16), 0));
        apply(mk(0, 0, 0, 8'h00, 5'd16, 0, 0));

        // Reset mid-WAIT: memory cleared, CPU stays held.
        #2;
        do_reset();
        apply(mk(0, 0, 0, 8'h00, 5'd0, 0, 0));
        apply(mk(0, 0, 0, 8'h00, 5'd0, 0, 0));

        // Run without load, then run_start in RUN is ignored.
        apply(mk(0, 1, 0, 8'h00, 5'd0, 0, 0));
        apply(mk(0, 0, 0, 8'h00, 5'd0, 0, 0));
        apply(mk(0, 0, 0, 8'h00, 5'd0, 0, 1));
        check_mem("run_zero_mem");
        apply(mk(0, 1, 0, 8'h00, 5'd0, 0, 1));
        apply(mk(0, 0, 0, 8'h00, 5'd0, 0, 1));

        // load_start and run_start together in HOLD: load wins.
        #2;
        do_reset();
        apply(mk(1, 1, 0, 8'h00, 5'd0, 1, 0));
        apply(mk(0, 0, 0, 8'h00, 5'd0, 1, 0));
        apply(mk(0, 0, 0, 8'h00, 5'd0, 1, 0));

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Instruction store and boot sequencer that sits directly upstream of the 4-bit `cpu`. It holds a 16 x 8-bit program that is loaded byte-serially over a valid/ready port, serves `opecode`/`imm` to the CPU from the CPU's `addr`, and holds the CPU in reset until a program load or an explicit run request completes.

## Interface

Parameters:
- `RELEASE_DELAY`, default 2: number of clock edges spent in WAIT before the CPU is released from reset. Legal range is 1..15.

Ports:
- `clk`  in  1: system clock; all state changes on the rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `load_start`  in  1: single-cycle pulse; begins or restarts a program load.
- `run_start`  in  1: single-cycle pulse; runs the current memory contents without loading.
- `load_valid`  in  1: `load_data` is valid this cycle.
- `load_data`  in  8: instruction byte. `[7:4]` is the opcode; `[3:0]` is the immediate.
- `load_ready`  out  1: the loader accepts a byte this cycle.
- `addr`  in  4: instruction address driven by the CPU.
- `opecode`  out  4: `mem[addr][7:4]`, combinational.
- `imm`  out  4: `mem[addr][3:0]`, combinational.
- `cpu_n_rst`  out  1: registered, active-low reset for the CPU.
- `load_count`  out  5: number of bytes accepted in the current or last load (0..16).

## Operation

- Memory is 16 x 8 flops. Every entry is cleared to 8'h00 on reset.
- States:
  - HOLD: entered from reset.
  - LOAD
  - WAIT
  - RUN
- `cpu_n_rst` is 0 in HOLD, LOAD and WAIT, and 1 only in RUN.
- HOLD:
  - `load_start` -> LOAD.
  - `run_start` -> WAIT.
  - If both are asserted in the same cycle, `load_start` wins.
- LOAD:
  - `load_ready` = 1.
  - On each edge with `load_valid` asserted: `mem[wptr]` <= `load_data`, `wptr` increments, and `load_count` increments.
  - The edge that accepts the 16th byte (`wptr` = 15) moves to WAIT with `load_count` = 16.
  - If `load_valid` is low, nothing is written and the state holds indefinitely.
  - `load_start` in LOAD restarts: `wptr` <= 0 and `load_count` <= 0. A byte presented in that same cycle is discarded.
- WAIT:
  - The counter `cnt` is cleared on entry and increments each edge.
  - At the edge where `cnt` == `RELEASE_DELAY-1`: state <= RUN and `cpu_n_rst` <= 1.
  - `load_start` in WAIT -> LOAD with the pointer and count cleared. `cpu_n_rst` stays 0.
- RUN:
  - `load_start` -> LOAD, and `cpu_n_rst` <= 0 on the same edge.
  - `run_start` is ignored.
- `load_ready` = 0 outside LOAD. `load_valid` outside LOAD has no effect.
- Reads are combinational from the flop array. A write lands at the clock edge, so a read of the same address in the write cycle returns the old contents.
- `wptr` is 4 bits and never wraps within a load, because the 16th accept leaves LOAD.
- Reset mid-operation (any state): memory cleared, `wptr` = 0, `load_count` = 0, `cnt` = 0, state = HOLD, `cpu_n_rst` = 0, immediately and asynchronously.

## Timing

- Reset values:
  - `cpu_n_rst` = 0
  - `load_ready` = 0
  - `load_count` = 0
  - `opecode` = 0
  - `imm` = 0 (memory is zero)
- `load_ready` rises in the cycle after the `load_start` edge.
- Byte accept: one byte per cycle maximum, with zero-bubble back-to-back transfers. A full load takes 16 cycles with `load_valid` held high.
- `cpu_n_rst` rises exactly `RELEASE_DELAY` edges after the edge that accepts byte 16.
  - For `run_start` from HOLD, it rises `RELEASE_DELAY` edges after the `run_start` edge.
- `cpu_n_rst` falls on the same edge that samples `load_start` in RUN.
- `opecode`/`imm` follow `addr` with no clock latency.

## Test plan

- **Reset defaults**: assert `n_rst` low mid-cycle -> `cpu_n_rst` = 0, `load_ready` = 0, `load_count` = 0 and `opecode`/`imm` = 0 for every `addr`, all without waiting for a clock edge.
- **Full load and release**:
  - Stimulus: `load_start`, then 16 back-to-back bytes 8'h30, 8'h01, … 8'hF3.
  - Response: `load_count` = 16. `cpu_n_rst` rises exactly 2 edges after the last accept. `addr` = 0 reads `opecode` = 3, `imm` = 0, and `addr` = 15 reads `opecode` = 15, `imm` = 3.
- **Stalled transfer**:
  - Stimulus: toggle `load_valid` 1,0,0,1 with data 8'hA5 then 8'h5A.
  - Response: only 2 bytes are written, at entries 0 and 1. `load_count` = 2 and the state remains LOAD.
- **Restart mid-load**:
  - Stimulus: after 5 bytes, pulse `load_start` with `load_valid` = 1 and data 8'hEE.
  - Response: 8'hEE is not written and `load_count` = 0. The next byte lands at entry 0.
- **Run without load and reload from RUN**:
  - Stimulus: `run_start` from HOLD; then, in RUN, pulse `load_start`.
  - Response: `cpu_n_rst` rises after 2 edges. The `load_start` in RUN drops `cpu_n_rst` to 0 on the sampling edge, and `load_ready` = 1 in the next cycle.
- **Reset mid-WAIT**: assert `n_rst` while in WAIT -> state = HOLD, memory reads 0 and `cpu_n_rst` stays 0. A later `run_start` releases the CPU with all-zero program memory.
